// File: rtl/filter_pkg.sv
// Shared types and helpers for the averaging filter and its frame loader.
// Holds loader state encoding, pixel type and the filter latency formula.
package filter_pkg;

  typedef enum logic [1:0] {LOAD, FLUSH, HOLD} ldr_state_t;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  function automatic int filt_latency(input int r_k, input int c_k);
    return $clog2(r_k * c_k) + 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column write pointer for raster-order frame assembly.
// Avoids divide/modulo on the linear pixel index.
module raster_counter #(
  parameter int R_I = 16,
  parameter int C_I = 16,
  parameter int RW  = $clog2(R_I),
  parameter int CW  = $clog2(C_I)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  input  logic          ld1,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          first,
  output logic          last
);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  assign row   = row_q;
  assign col   = col_q;
  assign first = (row_q == '0) && (col_q == '0);
  assign last  = (row_q == RW'(R_I-1)) && (col_q == CW'(C_I-1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (ld1) begin
      row_d = '0;
      col_d = CW'(1);
    end else if (inc) begin
      if (col_q == CW'(C_I-1)) begin
        col_d = '0;
        row_d = last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/frame_loader_ctrl.sv
// Frame loader: assembles a raster pixel stream into the filter image,
// runs the filter for its pipeline latency, then holds until acknowledged.
module frame_loader_ctrl
  import filter_pkg::*;
#(
  parameter int R_I = 16,
  parameter int C_I = 16,
  parameter int W_I = 8,
  parameter int R_K = 3,
  parameter int C_K = 3,
  parameter int LAT = filt_latency(R_K, C_K)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [W_I-1:0]                   pix_in,
  input  logic                             pix_valid,
  input  logic                             pix_sof,
  output logic                             pix_ready,
  output logic [R_I-1:0][C_I-1:0][W_I-1:0] img,
  output logic                             filt_cen,
  output logic                             frame_valid,
  input  logic                             frame_ack,
  output logic                             sync_err
);

  localparam int RW = $clog2(R_I);
  localparam int CW = $clog2(C_I);
  localparam int LW = $clog2(LAT + 1);

  ldr_state_t state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [R_I-1:0][C_I-1:0][W_I-1:0] img_q, img_d;
  logic cen_q, cen_d;
  logic fv_q, fv_d;
  logic err_q, err_d;

  logic xfer, inc, clr, ld1, wr_en, first, last;
  logic [RW-1:0] row, wr_row;
  logic [CW-1:0] col, wr_col;

  raster_counter #(.R_I(R_I), .C_I(C_I)) u_rc (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .clr   (clr),
    .ld1   (ld1),
    .row   (row),
    .col   (col),
    .first (first),
    .last  (last)
  );

  assign pix_ready   = (state_q == LOAD);
  assign xfer        = pix_valid & pix_ready;
  assign img         = img_q;
  assign filt_cen    = cen_q;
  assign frame_valid = fv_q;
  assign sync_err    = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cen_d   = 1'b0;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    inc     = 1'b0;
    clr     = 1'b0;
    ld1     = 1'b0;
    wr_en   = 1'b0;
    wr_row  = row;
    wr_col  = col;
    unique case (state_q)
      LOAD: begin
        if (xfer) begin
          if (pix_sof) begin
            // SOF always restarts at [0][0]; mid-frame it is a framing error
            wr_en  = 1'b1;
            wr_row = '0;
            wr_col = '0;
            ld1    = 1'b1;
            err_d  = ~first;
          end else if (first) begin
            err_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (last) begin
              clr     = 1'b1;
              state_d = FLUSH;
              cen_d   = 1'b1;
              cnt_d   = LW'(LAT - 1);
            end else begin
              inc = 1'b1;
            end
          end
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          fv_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - LW'(1);
          cen_d = 1'b1;
        end
      end
      HOLD: begin
        if (frame_ack) state_d = LOAD;
        else fv_d = 1'b1;
      end
      default: state_d = LOAD;
    endcase
    img_d = img_q;
    if (wr_en) img_d[wr_row][wr_col] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      img_q   <= '0;
      cen_q   <= 1'b0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      img_q   <= img_d;
      cen_q   <= cen_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_frame_loader_ctrl.sv
// Randomized scoreboard bench for frame_loader_ctrl against a
// pixel-index reference model of the loader's framing rules.
module tb_frame_loader_ctrl;
  import filter_pkg::*;

  localparam int R_I   = 16;
  localparam int C_I   = 16;
  localparam int W_I   = 8;
  localparam int LAT   = filt_latency(3, 3);
  localparam int NPIX  = R_I * C_I;
  localparam int NEVER = 32'h7fffffff;

  typedef logic [R_I-1:0][C_I-1:0][W_I-1:0] img_t;
  typedef struct {
    int   cyc;
    img_t img;
  } frame_exp_t;

  logic clk, rst;
  logic [W_I-1:0] pix_in;
  logic pix_valid, pix_sof, pix_ready;
  img_t img;
  logic filt_cen, frame_valid, frame_ack, sync_err;

  frame_loader_ctrl #(
    .R_I(R_I), .C_I(C_I), .W_I(W_I), .R_K(3), .C_K(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_ready   (pix_ready),
    .img         (img),
    .filt_cen    (filt_cen),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit armed = 0;

  frame_exp_t frame_q[$];
  int err_q[$];

  img_t live;
  int idx;
  bit accepting;
  int cen_start;
  int hold_from;

  function automatic string img_diff(input img_t a, input img_t b);
    for (int r = 0; r < R_I; r++)
      for (int c = 0; c < C_I; c++)
        if (a[r][c] !== b[r][c])
          return $sformatf("[%0d][%0d] got=%0h want=%0h",
                           r, c, a[r][c], b[r][c]);
    return "none";
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // reference model: consumes inputs at each rising edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        live = '0;
        idx = 0;
        accepting = 1;
        cen_start = -1000;
        hold_from = NEVER;
        frame_q.delete();
        err_q.delete();
        armed = 1;
      end else if (armed) begin
        if (pix_valid && accepting) begin
          if (pix_sof) begin
            if (idx != 0) err_q.push_back(cyc + 1);
            live[0][0] = pix_in;
            idx = 1;
          end else if (idx == 0) begin
            err_q.push_back(cyc + 1);
          end else begin
            live[idx / C_I][idx % C_I] = pix_in;
            idx++;
            if (idx == NPIX) begin
              idx = 0;
              accepting = 0;
              cen_start = cyc + 1;
              hold_from = cyc + LAT + 1;
              frame_q.push_back('{cyc: hold_from, img: live});
            end
          end
        end else if (!accepting && cyc >= hold_from && frame_ack) begin
          accepting = 1;
          hold_from = NEVER;
        end
      end
      cyc++;
    end
  end

  // per-cycle level checks against the model
  initial begin
    forever begin
      @(negedge clk);
      if (armed && !rst) begin
        chk("pix_ready", pix_ready, accepting);
        chk("filt_cen", filt_cen,
            (cyc >= cen_start) && (cyc < cen_start + LAT));
        chk("frame_valid", frame_valid,
            !accepting && (cyc >= hold_from));
        checks++;
        if (img !== live) begin
          failures++;
          $display("FAIL img_live cyc=%0d %s", cyc, img_diff(img, live));
        end
      end
    end
  end

  // scoreboard monitor: pops on sync_err pulses and frame_valid rises
  initial begin
    bit fv_prev = 0;
    forever begin
      @(negedge clk);
      if (armed && !rst) begin
        if (sync_err) begin
          checks++;
          if (err_q.size() == 0) begin
            failures++;
            $display("FAIL sync_err unexpected cyc=%0d got=1 want=0", cyc);
          end else begin
            int e;
            e = err_q.pop_front();
            if (e != cyc) begin
              failures++;
              $display("FAIL sync_err_cyc got=%0d want=%0d", cyc, e);
            end
          end
        end
        if (frame_valid && !fv_prev) begin
          checks++;
          if (frame_q.size() == 0) begin
            failures++;
            $display("FAIL frame unexpected cyc=%0d got=1 want=0", cyc);
          end else begin
            frame_exp_t f;
            f = frame_q.pop_front();
            if (f.cyc != cyc) begin
              failures++;
              $display("FAIL frame_cyc got=%0d want=%0d", cyc, f.cyc);
            end
            checks++;
            if (img !== f.img) begin
              failures++;
              $display("FAIL frame_img %s", img_diff(img, f.img));
            end
          end
        end
        fv_prev = frame_valid;
      end else begin
        fv_prev = 0;
      end
    end
  end

  task automatic send_pix(input logic [W_I-1:0] p, input bit sof,
                          input int gap);
    int n = 0;
    bit x;
    forever begin
      if (int'($urandom_range(99)) < gap) begin
        pix_valid = 0;
      end else begin
        pix_valid = 1;
        pix_in = p;
        pix_sof = sof;
      end
      x = pix_valid && pix_ready;
      @(negedge clk);
      if (x) break;
      n++;
      if (n > 2000) begin
        checks++;
        failures++;
        $display("FAIL pix_timeout got=stalled want=accepted");
        break;
      end
    end
  endtask

  task automatic send_frame(input int kind, input int gap);
    logic [W_I-1:0] v;
    for (int i = 0; i < NPIX; i++) begin
      if (kind == 0) v = i[W_I-1:0];
      else if (kind == 1) v = 8'd9;
      else v = W_I'($urandom);
      send_pix(v, i == 0, gap);
    end
  endtask

  task automatic ack_frame(input int delay);
    int n = 0;
    while (!frame_valid) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checks++;
        failures++;
        $display("FAIL fv_timeout got=0 want=1");
        return;
      end
    end
    repeat (delay) @(negedge clk);
    frame_ack = 1;
    @(negedge clk);
    frame_ack = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    rst = 1;
    pix_in = '0;
    pix_valid = 0;
    pix_sof = 0;
    frame_ack = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_ready", pix_ready, 1);
    chk("reset_fv", frame_valid, 0);

    // ramp frame, continuous valid
    send_frame(0, 0);
    pix_valid = 0;
    ack_frame(3);

    // constant 9 frame, long hold before ack
    send_frame(1, 0);
    pix_valid = 0;
    ack_frame(20);

    // missing SOF on first pixel, then a good frame
    send_pix(8'h77, 0, 0);
    send_frame(2, 0);
    pix_valid = 0;
    ack_frame(1);

    // early SOF at index 100
    for (int i = 0; i < 100; i++) send_pix(W_I'($urandom), i == 0, 0);
    send_pix(8'hAA, 1, 0);
    for (int i = 1; i < NPIX; i++) send_pix(W_I'($urandom), 0, 0);
    pix_valid = 0;
    repeat (LAT + 1) @(negedge clk);
    chk("early_sof_00", img[0][0], 8'hAA);
    ack_frame(0);

    // reset during third flush cycle
    send_frame(2, 0);
    pix_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_cen", filt_cen, 0);
    chk("rst_ready", pix_ready, 1);
    chk("rst_img", (img == '0), 1);
    repeat (20) @(negedge clk);

    // gapped back-to-back frames, ack on first valid cycle
    fork
      begin
        send_frame(2, 50);
        send_frame(2, 50);
        pix_valid = 0;
      end
      begin
        ack_frame(0);
        ack_frame(0);
      end
    join
    repeat (5) @(negedge clk);

    chk("err_q_empty", err_q.size(), 0);
    chk("frame_q_empty", frame_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
